// File: rtl/pc_unit.sv
// pc_unit: program counter (niaddr priority branch>jump/jal>jr>pc4, stall holds iaddr), optional return-address stack under PC_UNIT_RAS_EN; ports clk/rst/stall, control decodes in, iaddr/niaddr out, ras_empty/ras_full/ras_miss status out
module pc_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(32'h0000_3000),
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch,
  input  logic             zero,
  input  logic             jump,
  input  logic             jal,
  input  logic             jr,
  input  logic [15:0]      imm16,
  input  logic [25:0]      imm26,
  input  logic [WIDTH-1:0] jr_addr,
  output logic [WIDTH-1:0] iaddr,
  output logic [WIDTH-1:0] niaddr,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_miss
);
  logic [WIDTH-1:0] pc4;
  logic take_br, take_j, take_jr;
  assign pc4 = iaddr + WIDTH'(4);
  assign take_br = branch && zero;
  assign take_j = !take_br && (jump || jal);
  assign take_jr = !take_br && !jump && !jal && jr;
  assign niaddr = take_br ? pc4 + {{(WIDTH-18){imm16[15]}}, imm16, 2'b00} :
                  take_j  ? {iaddr[WIDTH-1:28], imm26, 2'b00} :
                  take_jr ? jr_addr : pc4;
  always_ff @(posedge clk)
    if (rst) iaddr <= RESET_ADDR;
    else if (!stall) iaddr <= niaddr;
`ifdef PC_UNIT_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0] top, top_inc, top_dec;
  logic [CW-1:0] cnt;
  logic push, pop;
  assign push = take_j && jal && !stall;
  assign pop = take_jr && !stall;
  assign top_inc = top == PW'(RAS_DEPTH - 1) ? '0 : top + 1'b1;
  assign top_dec = top == '0 ? PW'(RAS_DEPTH - 1) : top - 1'b1;
  assign ras_empty = cnt == '0;
  assign ras_full = cnt == CW'(RAS_DEPTH);
  always_ff @(posedge clk)
    if (push) mem[top_inc] <= pc4;
  // top always names the newest entry, so when full the slot after it holds the oldest and a push overwrites it
  always_ff @(posedge clk) begin
    if (rst) begin
      top <= '0;
      cnt <= '0;
      ras_miss <= 1'b0;
    end else begin
      ras_miss <= pop && (ras_empty || mem[top] != jr_addr);
      if (push) begin
        top <= top_inc;
        if (!ras_full) cnt <= cnt + 1'b1;
      end else if (pop && !ras_empty) begin
        top <= top_dec;
        cnt <= cnt - 1'b1;
      end
    end
  end
`else
  assign ras_empty = 1'b1;
  assign ras_full = 1'b0;
  assign ras_miss = 1'b0;
`endif
endmodule
